// File: rtl/seq_seg_adder_if.sv
// rtl/seq_seg_adder_if.sv - start/done request and result bus for seq_seg_adder
// Optional flag signals are present when SEQ_SEG_ADDER_FLAGS_EN is defined.
interface seq_seg_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SEQ_SEG_ADDER_FLAGS_EN
    logic             ovf;
    logic             zero;
`endif

    modport master (
        output start, in1, in2, cin, sub,
        input  busy, done, sum, cout
`ifdef SEQ_SEG_ADDER_FLAGS_EN
        , input ovf, zero
`endif
    );

    modport slave (
        input  start, in1, in2, cin, sub,
        output busy, done, sum, cout
`ifdef SEQ_SEG_ADDER_FLAGS_EN
        , output ovf, zero
`endif
    );
endinterface

// File: rtl/seq_seg_adder.sv
// rtl/seq_seg_adder.sv - multi-cycle add/sub using one SEG-bit ripple slice per clock
// Define SEQ_SEG_ADDER_FLAGS_EN to add registered ovf/zero result flags.
module seq_seg_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_seg_adder_if.slave    bus
);
    localparam int NSEG = WIDTH / SEG;
    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [IDXW-1:0]  idx;
    logic             c_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;

    logic [31:0]      ofs;
    logic [SEG-1:0]   s;
    logic             c_next;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    // acc_next includes the slice being produced so completion can publish it same edge.
    always_comb begin
        ofs      = 32'(idx) * 32'(SEG);
        {c_next, s} = {1'b0, a_r[ofs +: SEG]} + {1'b0, b_r[ofs +: SEG]} + {{SEG{1'b0}}, c_r};
        acc_next = acc;
        acc_next[ofs +: SEG] = s;
        last     = (idx == IDXW'(NSEG - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            c_r      <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
`ifdef SEQ_SEG_ADDER_FLAGS_EN
            bus.ovf  <= 1'b0;
            bus.zero <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r      <= bus.in1;
                        b_r      <= bus.sub ? ~bus.in2 : bus.in2;
                        c_r      <= bus.sub ? 1'b1 : bus.cin;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    c_r <= c_next;
                    idx <= idx + 1'b1;
                    if (last) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.sum  <= acc_next;
                        bus.cout <= c_next;
`ifdef SEQ_SEG_ADDER_FLAGS_EN
                        // b_r is already inverted for subtraction, so one rule covers both.
                        bus.ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                    (acc_next[WIDTH-1] != a_r[WIDTH-1]);
                        bus.zero <= (acc_next == '0);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
